prog_freq_divider: RTL and testbench

//  Programmable divide-by-N stage feeding the fixed counter/divider stages downstream.

---
 rtl/prog_freq_divider_pkg.sv | 13 +
 rtl/prog_freq_divider_div_reg.sv | 50 +++++
 rtl/prog_freq_divider.sv | 115 +++++++++++
 tb/tb_prog_freq_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_freq_divider_pkg.sv
// Shared definitions for the programmable divider and the downstream divider stages.
package prog_freq_divider_pkg;

   localparam int unsigned FDIV_DIV_MIN = 2;

   // How a pending divisor is being applied this cycle.
   typedef enum logic [1:0] {
      APPLY_NONE,
      APPLY_WRAP,
      APPLY_HOLD
   } apply_e;

endpackage

// File: rtl/prog_freq_divider_div_reg.sv
// Pending-divisor register: captures and clamps div_in, schedules its application, pulses div_ack.
module prog_freq_divider_div_reg
   import prog_freq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wrap,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic [WIDTH-1:0] pend,
   output apply_e           apply,
   output logic             div_ack
);

   logic             pend_v;
   logic [WIDTH-1:0] div_clamped;

   always_comb begin
      div_clamped = (div_in < WIDTH'(FDIV_DIV_MIN)) ? WIDTH'(FDIV_DIV_MIN) : div_in;
      apply       = APPLY_NONE;
      if (pend_v) begin
         if (!en)
            apply = APPLY_HOLD;
         else if (wrap)
            apply = APPLY_WRAP;
      end
   end

   // A load coinciding with an application keeps pend_v set: the old value is
   // consumed this edge while the new one waits for the next boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= WIDTH'(FDIV_DIV_MIN);
         pend_v  <= 1'b0;
         div_ack <= 1'b0;
      end else begin
         div_ack <= (apply != APPLY_NONE);
         if (div_load) begin
            pend   <= div_clamped;
            pend_v <= 1'b1;
         end else if (apply != APPLY_NONE) begin
            pend_v <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable divide-by-N stage: square wave fout, end-of-period tick, reloadable divisor.
// Optional quadrature output fout_q is built when FDIV_QUAD_EN is defined.
module prog_freq_divider
   import prog_freq_divider_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             fout,
   output logic             tick
`ifdef FDIV_QUAD_EN
   ,
   output logic             fout_q
`endif
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_cur;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] half;
   logic [WIDTH-1:0] pend;
   logic             wrap;
   apply_e           apply;

   function automatic logic [WIDTH-1:0] half_up(input logic [WIDTH-1:0] n);
      logic [WIDTH:0] t;
      t = {1'b0, n} + (WIDTH+1)'(1);
      return t[WIDTH:1];
   endfunction

`ifdef FDIV_QUAD_EN
   // Level of a copy of fout delayed by floor(d/4); c < d so one subtraction replaces the modulo.
   function automatic logic quad_level(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
      logic [WIDTH:0] s;
      s = {1'b0, c} + {1'b0, d} - {1'b0, d >> 2};
      if (s >= {1'b0, d})
         s = s - {1'b0, d};
      return s < {1'b0, half_up(d)};
   endfunction
`endif

   always_comb begin
      last     = div_cur - WIDTH'(1);
      half     = half_up(div_cur);
      wrap     = (cnt == last);
      cnt_next = wrap ? '0 : cnt + WIDTH'(1);
   end

   prog_freq_divider_div_reg #(
      .WIDTH (WIDTH)
   ) u_div_reg (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .wrap     (wrap),
      .div_in   (div_in),
      .div_load (div_load),
      .pend     (pend),
      .apply    (apply),
      .div_ack  (div_ack)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= WIDTH'(DEFAULT_DIV - 1);
         div_cur <= WIDTH'(DEFAULT_DIV);
         fout    <= 1'b0;
         tick    <= 1'b0;
`ifdef FDIV_QUAD_EN
         fout_q  <= 1'b0;
`endif
      end else begin
         case (apply)
            APPLY_WRAP: begin
               div_cur <= pend;
               cnt     <= '0;
               fout    <= 1'b1;
               tick    <= 1'b0;
`ifdef FDIV_QUAD_EN
               fout_q  <= quad_level(WIDTH'(0), pend);
`endif
            end
            APPLY_HOLD: begin
               div_cur <= pend;
               cnt     <= pend - WIDTH'(1);
               fout    <= 1'b0;
               tick    <= 1'b0;
`ifdef FDIV_QUAD_EN
               fout_q  <= quad_level(pend - WIDTH'(1), pend);
`endif
            end
            default: begin
               if (en) begin
                  cnt    <= cnt_next;
                  fout   <= (cnt_next < half);
                  tick   <= (cnt_next == last);
`ifdef FDIV_QUAD_EN
                  fout_q <= quad_level(cnt_next, div_cur);
`endif
               end else begin
                  tick   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider: directed vector table, corner sequences, randomized model check.
module tb_prog_freq_divider;

   localparam int DEF = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [7:0] div_in = '0;
   logic       div_load = 1'b0;
   logic       div_ack;
   logic       fout;
   logic       tick;
`ifdef FDIV_QUAD_EN
   logic       fout_q;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: position within the current period and the period length.
   int m_n, m_ph, m_pend;
   bit m_fout, m_tick, m_ack, m_fq;

   typedef struct {
      logic       r, e, l;
      logic [7:0] d;
      logic       f, t, a;
   } vec_t;

   prog_freq_divider #(
      .WIDTH       (8),
      .DEFAULT_DIV (DEF)
   ) dut (
`ifdef FDIV_QUAD_EN
      .fout_q   (fout_q),
`endif
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .div_ack  (div_ack),
      .fout     (fout),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic l, input int d);
      bit applied = 0;
      if (r) begin
         m_n = DEF; m_ph = DEF - 1; m_pend = -1; m_ack = 0; m_tick = 0;
      end else begin
         m_ack = 0;
         if (e) begin
            if (m_ph == m_n - 1 && m_pend >= 0) begin
               m_n = m_pend; m_ph = 0; applied = 1;
            end else begin
               m_ph = (m_ph + 1) % m_n;
            end
            m_tick = !applied && (m_ph == m_n - 1);
         end else begin
            m_tick = 0;
            if (m_pend >= 0) begin
               m_n = m_pend; m_ph = m_n - 1; applied = 1;
            end
         end
         if (applied) begin
            m_ack = 1; m_pend = -1;
         end
         if (l) m_pend = (d < 2) ? 2 : d;
      end
      m_fout = m_ph < (m_n + 1) / 2;
      m_fq   = ((m_ph + m_n - m_n / 4) % m_n) < (m_n + 1) / 2;
   endtask

   task automatic step(input logic r, input logic e, input logic l, input logic [7:0] d);
      @(negedge clk);
      rst = r; en = e; div_load = l; div_in = d;
      @(posedge clk);
      #1;
      model_step(r, e, l, int'(d));
   endtask

   task automatic wait_ack(input int budget, input string name);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'd0);
         got = div_ack;
      end
      check(name, int'(got), 1);
   endtask

   vec_t tbl[30];
   vec_t t3[8];

   initial begin
      int ticks, highs;
      logic fhist[$];

      // Reset, N=4; en=0 load 6; back-to-back loads 7 then 1 (clamped); load 0.
      tbl[0]  = '{1,1,0,0, 0,0,0};
      tbl[1]  = '{0,1,0,0, 1,0,0};
      tbl[2]  = '{0,1,0,0, 1,0,0};
      tbl[3]  = '{0,1,0,0, 0,0,0};
      tbl[4]  = '{0,1,0,0, 0,1,0};
      tbl[5]  = '{0,1,0,0, 1,0,0};
      tbl[6]  = '{0,1,0,0, 1,0,0};
      tbl[7]  = '{0,1,0,0, 0,0,0};
      tbl[8]  = '{0,1,0,0, 0,1,0};
      tbl[9]  = '{0,0,1,6, 0,0,0};
      tbl[10] = '{0,0,0,0, 0,0,1};
      tbl[11] = '{0,1,0,0, 1,0,0};
      tbl[12] = '{0,1,0,0, 1,0,0};
      tbl[13] = '{0,1,0,0, 1,0,0};
      tbl[14] = '{0,1,0,0, 0,0,0};
      tbl[15] = '{0,1,0,0, 0,0,0};
      tbl[16] = '{0,1,0,0, 0,1,0};
      tbl[17] = '{0,1,1,7, 1,0,0};
      tbl[18] = '{0,1,1,1, 1,0,0};
      tbl[19] = '{0,1,0,0, 1,0,0};
      tbl[20] = '{0,1,0,0, 0,0,0};
      tbl[21] = '{0,1,0,0, 0,0,0};
      tbl[22] = '{0,1,0,0, 0,1,0};
      tbl[23] = '{0,1,0,0, 1,0,1};
      tbl[24] = '{0,1,0,0, 0,1,0};
      tbl[25] = '{0,1,0,0, 1,0,0};
      tbl[26] = '{0,1,1,0, 0,1,0};
      tbl[27] = '{0,1,0,0, 1,0,1};
      tbl[28] = '{0,1,0,0, 0,1,0};
      tbl[29] = '{0,1,0,0, 1,0,0};

      // Load 3 at cnt=3 of an 8-cycle period: period finishes, then 1,1,0.
      t3[0] = '{0,1,1,3, 0,0,0};
      t3[1] = '{0,1,0,0, 0,0,0};
      t3[2] = '{0,1,0,0, 0,0,0};
      t3[3] = '{0,1,0,0, 0,1,0};
      t3[4] = '{0,1,0,0, 1,0,1};
      t3[5] = '{0,1,0,0, 1,0,0};
      t3[6] = '{0,1,0,0, 0,1,0};
      t3[7] = '{0,1,0,0, 1,0,0};

      for (int i = 0; i < 30; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d);
         check($sformatf("tbl%0d_fout", i), int'(fout), int'(tbl[i].f));
         check($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].t));
         check($sformatf("tbl%0d_ack", i), int'(div_ack), int'(tbl[i].a));
      end

      // N=5 over 1000 cycles from a period start.
      step(1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b0, 1'b1, 1'b1, 8'd5);
      wait_ack(12, "n5_ack");
      ticks = 0; highs = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'd0);
         ticks += int'(tick);
         highs += int'(fout);
      end
      check("n5_ticks", ticks, 200);
      check("n5_highs", highs, 600);

      // Mid-period load at N=8.
      step(1'b0, 1'b1, 1'b1, 8'd8);
      wait_ack(20, "n8_ack");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         step(t3[i].r, t3[i].e, t3[i].l, t3[i].d);
         check($sformatf("mid%0d_fout", i), int'(fout), int'(t3[i].f));
         check($sformatf("mid%0d_tick", i), int'(tick), int'(t3[i].t));
         check($sformatf("mid%0d_ack", i), int'(div_ack), int'(t3[i].a));
      end

      // Reset with a pending divisor outstanding.
      step(1'b0, 1'b1, 1'b1, 8'd9);
      step(1'b1, 1'b1, 1'b0, 8'd0);
      check("rst_fout", int'(fout), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_ack", int'(div_ack), 0);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 1'b1, 1'b0, 8'd0);
         check($sformatf("post_rst%0d_fout", k), int'(fout), int'((k % 4) < 2));
         check($sformatf("post_rst%0d_tick", k), int'(tick), int'((k % 4) == 3));
         check($sformatf("post_rst%0d_ack", k), int'(div_ack), 0);
      end

`ifdef FDIV_QUAD_EN
      step(1'b0, 1'b1, 1'b1, 8'd8);
      wait_ack(12, "quad_ack");
      fhist.delete();
      for (int k = 0; k < 24; k++) begin
         step(1'b0, 1'b1, 1'b0, 8'd0);
         fhist.push_back(fout);
         if (k >= 2)
            check($sformatf("quad_lag%0d", k), int'(fout_q), int'(fhist[k - 2]));
      end
`endif

      // Randomized run against the model.
      for (int i = 0; i < 4000; i++) begin
         logic r, e, l;
         logic [7:0] d;
         r = ($urandom_range(0, 499) == 0);
         e = ($urandom_range(0, 9) < 8);
         l = ($urandom_range(0, 19) == 0);
         d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(100, 255))
                                          : 8'($urandom_range(0, 12));
         step(r, e, l, d);
         check("rnd_fout", int'(fout), int'(m_fout));
         check("rnd_tick", int'(tick), int'(m_tick));
         check("rnd_ack", int'(div_ack), int'(m_ack));
`ifdef FDIV_QUAD_EN
         check("rnd_fout_q", int'(fout_q), int'(m_fq));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
